// File: rtl/masked_accum_seq_if.sv
// Sample/result bundle for masked_accum_seq: the source drives the master side,
// the accumulator sits on the slave side.
interface masked_accum_seq_if #(
    parameter int unsigned DW    = 4,
    parameter int unsigned AW    = 12,
    parameter int unsigned FRAME = 128
);
    localparam int unsigned CW = $clog2(FRAME + 1);

    logic          start_i;
    logic          in_valid_i;
    logic [DW-1:0] in_data_i;
    logic [DW-1:0] in_mask_i;
    logic          busy_o;
    logic [CW-1:0] count_o;
    logic [AW-1:0] out_sum_o;
    logic          out_valid_o;
    logic          overflow_o;

    modport slave (
        input  start_i, in_valid_i, in_data_i, in_mask_i,
        output busy_o, count_o, out_sum_o, out_valid_o, overflow_o
    );

    modport master (
        output start_i, in_valid_i, in_data_i, in_mask_i,
        input  busy_o, count_o, out_sum_o, out_valid_o, overflow_o
    );
endinterface

// File: rtl/masked_accum_seq.sv
// Frame accumulator of masked samples: one-stage input register feeding an AW-bit
// accumulator, with wrap or saturate arithmetic and a sticky overflow flag.
module masked_accum_seq #(
    parameter int unsigned DW    = 4,
    parameter int unsigned AW    = 12,
    parameter int unsigned FRAME = 128,
    parameter bit          SAT   = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    masked_accum_seq_if.slave  bus
);
    localparam int unsigned CW = $clog2(FRAME + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [AW-1:0] stage_q, stage_d;
    logic          stage_vld_q, stage_vld_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] sum_q, sum_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;

    logic [AW:0]   add_ext;
    logic [AW-1:0] acc_add;
    logic          carry;
    logic          frame_full;

    // One extra bit catches the carry out of the accumulator.
    always_comb begin
        add_ext = {1'b0, acc_q} + {1'b0, stage_q};
        carry   = stage_vld_q & add_ext[AW];
        acc_add = (add_ext[AW] && SAT) ? {AW{1'b1}} : add_ext[AW-1:0];
    end

    assign frame_full = (count_q == CW'(FRAME));

    // NOTE: every next-state signal gets its default first, so no path leaves one
    // unassigned and no latch can be inferred.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        stage_d     = stage_q;
        stage_vld_d = 1'b0;
        count_d     = count_q;
        sum_d       = sum_q;
        valid_d     = 1'b0;
        ovf_d       = ovf_q;

        if (state_q != S_IDLE && stage_vld_q) begin
            acc_d = acc_add;
            if (carry) ovf_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d = S_ACC;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_ACC: begin
                // The last accepted sample drains through the adder before FLUSH.
                if (frame_full) begin
                    state_d = S_FLUSH;
                end else if (bus.in_valid_i) begin
                    stage_d     = {{(AW-DW){1'b0}}, bus.in_data_i & bus.in_mask_i};
                    stage_vld_d = 1'b1;
                    count_d     = count_q + CW'(1);
                end
            end
            S_FLUSH: begin
                sum_d   = stage_vld_q ? acc_add : acc_q;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
            count_q     <= '0;
            sum_q       <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            stage_q     <= stage_d;
            stage_vld_q <= stage_vld_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.count_o     = count_q;
    assign bus.out_sum_o   = sum_q;
    assign bus.out_valid_o = valid_q;
    assign bus.overflow_o  = ovf_q;
endmodule
